spart_bus_fifo_if: RTL and testbench

Buffered, parametrised processor-side bus interface for the SPART serial port. Decodes the 2-bit I/O address space, owns the bidirectional databus, buffers received characters in an RX FIFO and outgoing characters in a TX FIFO, and holds the baud divisor register with an atomic two-byte commit. Sits between the processor I/O bus and the SPART transmitter, receiver and baud generator.

---
 rtl/spart_bus_fifo_if.sv | 146 ++++++++++++++
 tb/tb_spart_bus_fifo_if.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_fifo_if.sv
// Processor bus interface for the SPART: address decode, RX/TX character FIFOs and baud divisor.
// Optional macro SPART_RX_OVF_EN adds a sticky RX overflow flag (port rx_ovf, status bit DATA_W-1).
module spart_bus_fifo_if #(
    parameter int                      DATA_W     = 8,
    parameter int                      FIFO_DEPTH = 4,
    parameter logic [2*DATA_W-1:0]     BAUD_RESET = 16'h028B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iocs,
    input  logic                  iorw,
    input  logic [1:0]            ioaddr,
    inout  wire  [DATA_W-1:0]     databus,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_start,
    output logic [2*DATA_W-1:0]   baud_div,
`ifdef SPART_RX_OVF_EN
    output logic                  rx_ovf,
`endif
    output logic                  baud_load
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [CNT_W-1:0]  rx_count, tx_count, tx_free;
    logic [DATA_W-1:0] baud_low;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] status;

    logic rd_acc, wr_acc;
    logic rx_pop, rx_push, rx_full;
    logic tx_push, tx_drain, tx_full;

    assign rd_acc   = iocs & iorw;
    assign wr_acc   = iocs & ~iorw;
    assign rx_full  = (rx_count == DEPTH_C);
    assign tx_full  = (tx_count == DEPTH_C);
    assign tx_free  = DEPTH_C - tx_count;

    assign rx_pop   = rd_acc && (ioaddr == 2'b00) && (rx_count != '0);
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign tx_drain = (tx_count != '0) && tx_ready && !tx_start;
    assign tx_push  = wr_acc && (ioaddr == 2'b00) && (!tx_full || tx_drain);

    assign databus  = rd_acc ? rd_data : {DATA_W{1'bz}};

    always_comb begin
        status = '0;
        status[CNT_W-1:0]       = rx_count;
        status[2*CNT_W-1:CNT_W] = tx_free;
`ifdef SPART_RX_OVF_EN
        status[DATA_W-1]        = rx_ovf;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (ioaddr)
            2'b00:   if (rx_count != '0) rd_data = rx_mem[rx_rptr];
            2'b01:   rd_data = status;
            2'b10:   rd_data = baud_div[DATA_W-1:0];
            default: rd_data = baud_div[2*DATA_W-1:DATA_W];
        endcase
    end

    // Storage arrays need no reset: the counts gate every read of them.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
        if (tx_push) tx_mem[tx_wptr] <= databus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_W'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_W'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_W'(1);
                2'b01:   rx_count <= rx_count - CNT_W'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // A drain loads tx_data and pops the head on the same edge that raises tx_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= tx_drain;
            if (tx_drain) begin
                tx_data <= tx_mem[tx_rptr];
                tx_rptr <= tx_rptr + PTR_W'(1);
            end
            if (tx_push) tx_wptr <= tx_wptr + PTR_W'(1);
            case ({tx_push, tx_drain})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // The low byte waits in a shadow until the high-byte write commits both halves together.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_low  <= BAUD_RESET[DATA_W-1:0];
            baud_div  <= BAUD_RESET;
            baud_load <= 1'b0;
        end else begin
            baud_load <= 1'b0;
            if (wr_acc && (ioaddr == 2'b10)) baud_low <= databus;
            if (wr_acc && (ioaddr == 2'b11)) begin
                baud_div  <= {databus, baud_low};
                baud_load <= 1'b1;
            end
        end
    end

`ifdef SPART_RX_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)
            rx_ovf <= 1'b0;
        else if (rx_valid && rx_full && !rx_pop)
            rx_ovf <= 1'b1;
        else if (wr_acc && (ioaddr == 2'b01))
            rx_ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Self-checking bench for spart_bus_fifo_if: vector table plus RX/TX scoreboards and corner sequences.
module tb_spart_bus_fifo_if;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              iocs = 1'b0;
    logic              iorw = 1'b0;
    logic [1:0]        ioaddr = 2'b00;
    wire  [DATA_W-1:0] databus;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic [15:0]       baud_div;
    logic              baud_load;
`ifdef SPART_RX_OVF_EN
    logic              rx_ovf;
`endif

    logic [DATA_W-1:0] drv = '0;
    logic              drv_en = 1'b0;
    assign databus = drv_en ? drv : {DATA_W{1'bz}};

    spart_bus_fifo_if dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start),
        .baud_div(baud_div),
`ifdef SPART_RX_OVF_EN
        .rx_ovf(rx_ovf),
`endif
        .baud_load(baud_load)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] bus_rd;
    logic              s_start, s_load;
    logic [15:0]       s_div;

    logic [DATA_W-1:0] rx_q [$];
    logic [DATA_W-1:0] tx_q [$];
    logic              prev_start = 1'b0;

    typedef struct {
        bit          cs;
        bit          rw;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        bit          rxv;
        logic [7:0]  rxd;
        bit          chk;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One bus/serial cycle: drive after the edge, sample at the falling edge.
    task automatic applyStimulus(input bit cs, input bit rw, input logic [1:0] addr,
                                 input logic [7:0] wdata, input bit rxv, input logic [7:0] rxd);
        iocs     = cs;
        iorw     = rw;
        ioaddr   = addr;
        drv      = wdata;
        drv_en   = cs && !rw;
        rx_valid = rxv;
        rx_data  = rxd;
        @(negedge clk);
        bus_rd  = databus;
        s_start = tx_start;
        s_load  = baud_load;
        s_div   = baud_div;
        @(posedge clk);
        #1;
        iocs     = 1'b0;
        iorw     = 1'b0;
        drv_en   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic waitTxEmpty(input int budget);
        int n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            idle();
            n++;
        end
        checkOutput("tx_drain_done", 16'(tx_q.size()), 16'd0);
    endtask

    // TX scoreboard: every tx_start must carry the oldest accepted write and never follow another start.
    always @(negedge clk) begin
        if (!rst && tx_start === 1'b1) begin
            checkOutput("tx_no_back_to_back", {15'd0, prev_start}, 16'd0);
            if (tx_q.size() == 0)
                checkOutput("tx_unexpected_start", 16'd1, 16'd0);
            else
                checkOutput("tx_data", {8'd0, tx_data}, {8'd0, tx_q.pop_front()});
        end
        prev_start = tx_start;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        logic [7:0] ovf_bit;
`ifdef SPART_RX_OVF_EN
        ovf_bit = 8'h80;
`else
        ovf_bit = 8'h00;
`endif
        //            cs rw addr   wdata  rxv rxd    chk exp    name
        vecs[0]  = '{1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h20, "rst_status"};
        vecs[1]  = '{1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'h00, "rst_rx_empty"};
        vecs[2]  = '{1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h20, "empty_pop_no_change"};
        vecs[3]  = '{1, 1, 2'b10, 8'h00, 0, 8'h00, 1, 8'h8B, "rst_baud_low"};
        vecs[4]  = '{1, 1, 2'b11, 8'h00, 0, 8'h00, 1, 8'h02, "rst_baud_high"};
        vecs[5]  = '{0, 0, 2'b00, 8'h00, 1, 8'hA1, 0, 8'h00, "rx_push_a1"};
        vecs[6]  = '{1, 1, 2'b01, 8'h00, 1, 8'hB2, 1, 8'h21, "rx_count_1"};
        vecs[7]  = '{1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h22, "rx_count_2"};
        vecs[8]  = '{1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'hA1, "rx_read_a1"};
        vecs[9]  = '{1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h21, "rx_count_after_pop1"};
        vecs[10] = '{1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'hB2, "rx_read_b2"};
        vecs[11] = '{1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h20, "rx_count_0"};
        vecs[12] = '{1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 8'h00, "rx_read_empty"};
        vecs[13] = '{1, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8'h20, "rx_still_empty"};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle();
        checkOutput("rst_tx_start", {15'd0, s_start}, 16'd0);
        checkOutput("rst_tx_data", {8'd0, tx_data}, 16'd0);
        checkOutput("rst_baud_load", {15'd0, s_load}, 16'd0);
        checkOutput("rst_baud_div", s_div, 16'h028B);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rxv, vecs[i].rxd);
            if (vecs[i].chk) checkOutput(vecs[i].name, {8'd0, bus_rd}, {8'd0, vecs[i].exp});
        end

        $display("[TB] RX overflow and full-FIFO pop/push");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'hC0 + 8'(i));
            if (rx_q.size() < 4) rx_q.push_back(8'hC0 + 8'(i));
        end
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("rx_full_status", {8'd0, bus_rd}, {8'd0, 8'h24 | ovf_bit});
`ifdef SPART_RX_OVF_EN
        checkOutput("rx_ovf_set", {15'd0, rx_ovf}, 16'd1);
        applyStimulus(1'b1, 1'b0, 2'b01, 8'hFF, 1'b1, 8'hEE);
        checkOutput("rx_ovf_drop_wins", {15'd0, rx_ovf}, 16'd1);
        applyStimulus(1'b1, 1'b0, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("rx_ovf_cleared", {15'd0, rx_ovf}, 16'd0);
        ovf_bit = 8'h00;
`endif
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 8'hD5);
        checkOutput("rx_full_pop_push", {8'd0, bus_rd}, {8'd0, rx_q.pop_front()});
        rx_q.push_back(8'hD5);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("rx_full_count_kept", {8'd0, bus_rd}, 16'h0024);
        while (rx_q.size() != 0) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00);
            checkOutput("rx_drain", {8'd0, bus_rd}, {8'd0, rx_q.pop_front()});
        end
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("rx_drained_status", {8'd0, bus_rd}, 16'h0020);

        $display("[TB] TX full FIFO with transmitter busy");
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 8'h10 + 8'(i), 1'b0, 8'h00);
            if (tx_q.size() < 4) tx_q.push_back(8'h10 + 8'(i));
        end
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("tx_full_status", {8'd0, bus_rd}, 16'h0004 & 16'h0000);
        checkOutput("tx_busy_no_start", {15'd0, s_start}, 16'd0);
        tx_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
            if (s_start) begin
                found = 1'b1;
                checkOutput("tx_free_after_start", {8'd0, bus_rd}, 16'h0008);
            end
        end
        checkOutput("tx_start_seen", {15'd0, found}, 16'd1);
        waitTxEmpty(60);
        repeat (3) idle();
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("tx_empty_status", {8'd0, bus_rd}, 16'h0020);

        $display("[TB] TX back-to-back writes");
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h55, 1'b0, 8'h00);
        tx_q.push_back(8'h55);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h66, 1'b0, 8'h00);
        tx_q.push_back(8'h66);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            idle();
            if (s_start) found = 1'b1;
        end
        checkOutput("tx_first_start", {15'd0, found}, 16'd1);
        idle();
        checkOutput("tx_gap_cycle", {15'd0, s_start}, 16'd0);
        idle();
        checkOutput("tx_second_start", {15'd0, s_start}, 16'd1);
        waitTxEmpty(20);

        $display("[TB] Baud divisor commit");
        applyStimulus(1'b1, 1'b0, 2'b10, 8'h34, 1'b0, 8'h00);
        idle();
        checkOutput("baud_low_no_commit", s_div, 16'h028B);
        checkOutput("baud_low_no_load", {15'd0, s_load}, 16'd0);
        applyStimulus(1'b1, 1'b0, 2'b11, 8'h12, 1'b0, 8'h00);
        idle();
        checkOutput("baud_commit", s_div, 16'h1234);
        checkOutput("baud_load_pulse", {15'd0, s_load}, 16'd1);
        idle();
        checkOutput("baud_load_one_cycle", {15'd0, s_load}, 16'd0);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 8'h00);
        checkOutput("baud_read_low", {8'd0, bus_rd}, 16'h0034);
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00);
        checkOutput("baud_read_high", {8'd0, bus_rd}, 16'h0012);

        $display("[TB] Reset mid-operation");
        tx_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'hE1);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h71, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 2'b10, 8'h99, 1'b0, 8'h00);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b11, 8'hEE, 1'b1, 8'hE2);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
        checkOutput("reset_status", {8'd0, bus_rd}, 16'h0020);
        checkOutput("reset_baud_div", s_div, 16'h028B);
        checkOutput("reset_no_load", {15'd0, s_load}, 16'd0);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00);
        checkOutput("reset_rx_empty", {8'd0, bus_rd}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 2'b11, 8'h77, 1'b0, 8'h00);
        idle();
        checkOutput("reset_shadow_low", s_div, 16'h778B);
        tx_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (s_start) found = 1'b1;
        end
        checkOutput("reset_tx_flushed", {15'd0, found}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
